// File: rtl/mem_block_reader.sv
// Block reader: streams len consecutive words from a 1-cycle-latency synchronous RAM
// onto a valid/ready output, then pulses done. All outputs come straight from flops.
module mem_block_reader #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  // state | meaning
  // IDLE  | waiting for start; len=0 requests only pulse done
  // READ  | mem_en high for exactly one cycle at addr
  // CAPT  | RAM data arrives; registered into out_data at the end of this cycle
  // HOLD  | word presented until the consumer accepts it
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_CAPT, ST_HOLD} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] remain_q, remain_d;
  logic          mem_en_q, mem_en_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Outputs are computed one cycle ahead so they can be registered without extra latency.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    mem_en_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    busy_d      = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            addr_d     = base_addr;
            remain_d   = len;
            mem_en_d   = 1'b1;
            mem_addr_d = base_addr;
            busy_d     = 1'b1;
            state_d    = ST_READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        out_data_d  = mem_rdata;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (remain_q == LW'(1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            // address wraps modulo 2^AW by plain overflow
            remain_d   = remain_q - LW'(1);
            addr_d     = addr_q + AW'(1);
            mem_en_d   = 1'b1;
            mem_addr_d = addr_q + AW'(1);
            state_d    = ST_READ;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mem_block_reader.sv
// Scoreboard bench for mem_block_reader: stimulus pushes expected addresses/words,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_block_reader;
  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [7:0] len = '0;
  logic       busy, done, mem_en, out_valid;
  logic [7:0] mem_addr, out_data;
  logic [7:0] mem_rdata = '0;
  logic       out_ready = 1'b0;

  mem_block_reader #(.AW(8), .DW(8), .LW(8)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low
  int cyc = 0;
  int last_acc = -1;
  int done_cnt = 0;
  int memen_cnt = 0;
  bit spacing_chk = 1'b0;
  bit model_busy = 1'b0;
  bit done_due = 1'b0;
  bit mb, dd, fin;
  logic [8:0] exp_q[$];      // {last, data}
  logic [7:0] addr_exp_q[$];
  logic [7:0] seen_q[$];
  logic [7:0] seen_addr_q[$];
  logic [8:0] e;
  logic [7:0] a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a transfer is a list of (base+k) mod 256 addresses and their words.
  always @(negedge clk) begin
    cyc++;
    if (!clr_n) begin
      exp_q.delete();
      addr_exp_q.delete();
      model_busy = 1'b0;
      done_due = 1'b0;
      last_acc = -1;
    end else begin
      mb = model_busy;
      dd = 1'b0;
      fin = 1'b0;
      chk("busy", busy, mb);
      chk("done", done, done_due);
      if (done) done_cnt++;
      if (mem_en) begin
        memen_cnt++;
        seen_addr_q.push_back(mem_addr);
        chk("mem_en_expected", addr_exp_q.size() != 0, 1);
        if (addr_exp_q.size() != 0) chk("mem_addr", mem_addr, addr_exp_q.pop_front());
      end
      if (out_valid) begin
        chk("out_valid_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          chk("out_data", out_data, e[7:0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            seen_q.push_back(out_data);
            if (spacing_chk && last_acc >= 0) chk("spacing", cyc - last_acc, 3);
            last_acc = e[8] ? -1 : cyc;
            if (e[8]) begin
              fin = 1'b1;
              dd = 1'b1;
            end
          end
        end
      end
      if (start && !mb) begin
        if (len == 0) dd = 1'b1;
        else for (int k = 0; k < int'(len); k++) begin
          a = base_addr + 8'(k);
          addr_exp_q.push_back(a);
          exp_q.push_back({k == int'(len) - 1, a ^ 8'hA5});
        end
      end
      model_busy = (mb && !fin) || (start && !mb && len != 0);
      done_due = dd;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic do_start(input logic [7:0] b, input logic [7:0] l);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = b;
    len = l;
    @(posedge clk);
    #1;
    start = 1'b0;
    base_addr = 8'($urandom);
    len = 8'($urandom);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((model_busy || done_due || exp_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_timeout"}, n < budget, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_valid_timeout"}, n < budget, 1);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_mem_en"}, mem_en, 0);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_out_data"}, out_data, 0);
    chk({name, "_mem_addr"}, mem_addr, 0);
  endtask

  int d0, m0;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    clr_n = 1'b1;

    // basic sequence with ready held high
    rdy_mode = 0;
    spacing_chk = 1'b1;
    seen_q.delete(); seen_addr_q.delete();
    d0 = done_cnt; m0 = memen_cnt;
    do_start(8'h10, 8'd3);
    wait_idle("basic", 50);
    spacing_chk = 1'b0;
    chk("basic_n", seen_q.size(), 3);
    chk("basic_w0", seen_q[0], 8'hB5);
    chk("basic_w1", seen_q[1], 8'hB4);
    chk("basic_w2", seen_q[2], 8'hB7);
    chk("basic_a0", seen_addr_q[0], 8'h10);
    chk("basic_a2", seen_addr_q[2], 8'h12);
    chk("basic_memen", memen_cnt - m0, 3);
    chk("basic_done", done_cnt - d0, 1);

    // backpressure stall on the first word
    rdy_mode = 2;
    seen_q.delete();
    d0 = done_cnt; m0 = memen_cnt;
    do_start(8'h20, 8'd2);
    wait_valid("stall", 20);
    for (int i = 0; i < 5; i++) begin
      chk("stall_data", out_data, 8'h85);
      chk("stall_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    chk("stall_memen", memen_cnt - m0, 1);
    rdy_mode = 0;
    wait_idle("stall", 50);
    chk("stall_w0", seen_q[0], 8'h85);
    chk("stall_w1", seen_q[1], 8'h84);
    chk("stall_done", done_cnt - d0, 1);

    // address wrap
    seen_q.delete(); seen_addr_q.delete();
    do_start(8'hFE, 8'd4);
    wait_idle("wrap", 60);
    chk("wrap_a1", seen_addr_q[1], 8'hFF);
    chk("wrap_a2", seen_addr_q[2], 8'h00);
    chk("wrap_a3", seen_addr_q[3], 8'h01);
    chk("wrap_w0", seen_q[0], 8'h5B);
    chk("wrap_w1", seen_q[1], 8'h5A);
    chk("wrap_w2", seen_q[2], 8'hA5);
    chk("wrap_w3", seen_q[3], 8'hA4);

    // zero length
    d0 = done_cnt; m0 = memen_cnt;
    do_start(8'h33, 8'd0);
    wait_idle("len0", 10);
    chk("len0_done", done_cnt - d0, 1);
    chk("len0_memen", memen_cnt - m0, 0);

    // start while busy is ignored
    seen_q.delete();
    m0 = memen_cnt;
    do_start(8'h30, 8'd3);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 8'h80; len = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("midstart", 60);
    chk("midstart_n", seen_q.size(), 3);
    chk("midstart_w0", seen_q[0], 8'h95);
    chk("midstart_w2", seen_q[2], 8'h97);
    chk("midstart_memen", memen_cnt - m0, 3);

    // back-to-back: second start sampled at the end of the done cycle
    seen_q.delete();
    do_start(8'h50, 8'd1);
    repeat (2) @(posedge clk);
    do_start(8'h60, 8'd1);
    wait_idle("b2b", 30);
    chk("b2b_n", seen_q.size(), 2);
    chk("b2b_w1", seen_q[1], 8'hC5);

    // abort during HOLD, then restart
    rdy_mode = 2;
    do_start(8'h40, 8'd5);
    wait_valid("abort", 20);
    d0 = done_cnt;
    clr_n = 1'b0;
    #1;
    chk_all_zero("abort");
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    rdy_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_nodone", done_cnt - d0, 0);
    seen_q.delete();
    do_start(8'h00, 8'd1);
    wait_idle("restart", 30);
    chk("restart_w0", seen_q[0], 8'hA5);
    chk("restart_done", done_cnt - d0, 1);

    // randomized transfers with random backpressure
    rdy_mode = 1;
    for (int t = 0; t < 25; t++) begin
      do_start(8'($urandom), 8'($urandom_range(0, 6)));
      if ($urandom_range(0, 3) == 0) begin
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      wait_idle("rand", 300);
    end
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("end_exp_empty", exp_q.size(), 0);
    chk("end_addr_empty", addr_exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
